// File: rtl/cpu_boot_checker.sv
// cpu_boot_checker
//   Boot and self-test sequencer for the pipelined MIPS processor. It holds the
//   core in reset and copies NUM_INSTR words from an external program table into
//   instruction memory. It then releases the core and compares each register-file
//   writeback, in order, against an external expected table. At the end it
//   reports pass or fail. Nothing pokes the processor hierarchy, so the same
//   block works in simulation and on an FPGA.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   start               pulse; accepted only in IDLE or DONE
//   prog_idx/prog_word  program-table index out, word in (table is combinational)
//   im_we/im_addr/im_wdata  instruction-memory write port (byte address)
//   cpu_reset           active-high reset driven to the processor
//   wb_valid/wb_reg/wb_data  processor register-file write observed this cycle
//   exp_idx/exp_reg/exp_data expected-table index out, entry in (combinational)
//   busy/done/pass      status; pass is meaningful only while done=1
//   fail_code           0 none, 1 reg/data mismatch, 2 timeout
//   fail_idx            check index at the point of failure
//   cycles              number of RUN-phase cycles (saturating)
//
// Optional feature (macro CHECKER_TRACE_EN)
//   Adds a 4-entry circular capture of the most recent writebacks {wb_reg,wb_data}.
//   It is read through trace_rd_idx and trace_rd_data, with a registered read.
//   The capture is cleared on start and on reset, and frozen outside RUN.

module cpu_boot_checker #(
  parameter int DATA_W     = 32,
  parameter int NUM_INSTR  = 8,
  parameter int NUM_CHECKS = 8,
  parameter int ADDR_STEP  = 4,
  parameter int TIMEOUT    = 400,
  localparam int PI_W = (NUM_INSTR  > 1) ? $clog2(NUM_INSTR)  : 1,
  localparam int CI_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [PI_W-1:0]   prog_idx,
  input  logic [DATA_W-1:0] prog_word,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_reset,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [CI_W-1:0]   exp_idx,
  input  logic [4:0]        exp_reg,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CI_W-1:0]   fail_idx,
  output logic [31:0]       cycles
`ifdef CHECKER_TRACE_EN
  ,
  input  logic [1:0]          trace_rd_idx,
  output logic [5+DATA_W-1:0] trace_rd_data
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [PI_W-1:0] LAST_INSTR = PI_W'(NUM_INSTR - 1);
  localparam logic [CI_W-1:0] LAST_CHECK = CI_W'(NUM_CHECKS - 1);
  localparam logic [31:0]     STEP32     = 32'(ADDR_STEP);
  localparam logic [31:0]     TIMEOUT32  = 32'(TIMEOUT);

  logic [1:0]  state;
  logic        start_ok;
  logic        wb_check;
  logic        wb_match;
  logic [31:0] cycles_inc;

  // The program table is combinational on prog_idx. The address and strobe are
  // registered in lockstep with prog_idx, so the word lines up with them
  // without an extra pipeline stage.
  assign im_wdata = prog_word;

  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  // Writes to R0 are architecturally discarded, so they never consume a check.
  assign wb_check   = (state == S_RUN) && wb_valid && (wb_reg != 5'd0);
  assign wb_match   = (wb_reg == exp_reg) && (wb_data == exp_data);
  assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      prog_idx  <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      cpu_reset <= 1'b1;
      exp_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= 2'd0;
      fail_idx  <= '0;
      cycles    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state     <= S_LOAD;
            prog_idx  <= '0;
            im_addr   <= '0;
            im_we     <= 1'b1;
            cpu_reset <= 1'b1;
            exp_idx   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= 2'd0;
            fail_idx  <= '0;
            cycles    <= '0;
          end
        end
        S_LOAD: begin
          if (prog_idx == LAST_INSTR) begin
            state     <= S_RUN;
            im_we     <= 1'b0;
            cpu_reset <= 1'b0;
          end else begin
            prog_idx <= prog_idx + 1'b1;
            im_addr  <= im_addr + STEP32;
          end
        end
        default: begin // S_RUN
          cycles <= cycles_inc;
          // A writeback decision takes priority over the timeout in the same
          // cycle. After a non-final match, an expired budget is still seen
          // on the next cycle because the compare is >=.
          if (wb_check) begin
            if (!wb_match) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_reset <= 1'b1;
              fail_code <= 2'd1;
              fail_idx  <= exp_idx;
            end else if (exp_idx == LAST_CHECK) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_reset <= 1'b1;
              pass      <= 1'b1;
            end else begin
              exp_idx <= exp_idx + 1'b1;
            end
          end else if (cycles_inc >= TIMEOUT32) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b1;
            fail_code <= 2'd2;
            fail_idx  <= exp_idx;
          end
        end
      endcase
    end
  end

`ifdef CHECKER_TRACE_EN
  logic [1:0]          trace_wr_ptr;
  logic [5+DATA_W-1:0] trace_mem [4];
  logic                trace_wr;

  // Every RUN-phase writeback is captured, including R0 writes.
  assign trace_wr = (state == S_RUN) && wb_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trace_wr_ptr <= 2'd0;
    end else if (start_ok) begin
      trace_wr_ptr <= 2'd0;
    end else if (trace_wr) begin
      trace_wr_ptr <= trace_wr_ptr + 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_trace
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          trace_mem[gi] <= '0;
        end else if (start_ok) begin
          trace_mem[gi] <= '0;
        end else if (trace_wr && (trace_wr_ptr == 2'(gi))) begin
          trace_mem[gi] <= {wb_reg, wb_data};
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trace_rd_data <= '0;
    end else begin
      trace_rd_data <= trace_mem[trace_rd_idx];
    end
  end
`endif

endmodule

// File: tb/tb_cpu_boot_checker.sv
// Directed self-checking bench for cpu_boot_checker.
// The DUT is built with NUM_INSTR=7, NUM_CHECKS=2 and TIMEOUT=20.
// The bench drives the writeback bus directly, in place of a processor core.
module tb_cpu_boot_checker;
  localparam int DATA_W = 32;
  localparam int NI     = 7;
  localparam int NC     = 2;
  localparam int TO     = 20;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        prog_idx;
  logic [DATA_W-1:0] prog_word;
  logic              im_we;
  logic [31:0]       im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_reset;
  logic              wb_valid;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [0:0]        exp_idx;
  logic [4:0]        exp_reg;
  logic [DATA_W-1:0] exp_data;
  logic              busy, done, pass;
  logic [1:0]        fail_code;
  logic [0:0]        fail_idx;
  logic [31:0]       cycles;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] prog_tab [8];
  logic [4:0]        exp_tab_reg  [2];
  logic [DATA_W-1:0] exp_tab_data [2];

  assign prog_word = prog_tab[prog_idx];
  assign exp_reg   = exp_tab_reg[exp_idx];
  assign exp_data  = exp_tab_data[exp_idx];

  cpu_boot_checker #(
    .DATA_W(DATA_W), .NUM_INSTR(NI), .NUM_CHECKS(NC), .ADDR_STEP(4), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .prog_idx(prog_idx), .prog_word(prog_word),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset(cpu_reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .exp_idx(exp_idx), .exp_reg(exp_reg), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_idx(fail_idx), .cycles(cycles)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called just after the start edge: checks all NI load cycles and the
  // handover to RUN. A start pulse is injected mid-load and must be ignored.
  task automatic load_and_check(input bit poke_start);
    for (int i = 0; i < NI; i++) begin
      check("load_we",    {63'd0, im_we}, 64'd1);
      check("load_addr",  {32'd0, im_addr}, 64'(i * 4));
      check("load_data",  {32'd0, im_wdata}, {32'd0, prog_tab[i]});
      check("load_cpurst", {63'd0, cpu_reset}, 64'd1);
      $display("load word %0d addr=%0d data=%08h", i, im_addr, im_wdata);
      start = poke_start && (i == 2);
      step();
    end
    start = 1'b0;
    check("run_we",     {63'd0, im_we}, 64'd0);
    check("run_cpurst", {63'd0, cpu_reset}, 64'd0);
    check("run_busy",   {63'd0, busy}, 64'd1);
  endtask

  task automatic wb(input logic [4:0] r, input logic [DATA_W-1:0] d);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    step();
    wb_valid = 1'b0;
    $display("writeback R%0d=%0h exp_idx=%0d done=%0d", r, d, exp_idx, done);
  endtask

  initial begin
    prog_tab[0] = 32'h05490002; prog_tab[1] = 32'h00220020;
    prog_tab[2] = 32'h8C030004; prog_tab[3] = 32'hAC030008;
    prog_tab[4] = 32'h10000001; prog_tab[5] = 32'h00000000;
    prog_tab[6] = 32'h20640003; prog_tab[7] = 32'hDEADBEEF;
    exp_tab_reg[0] = 5'd9; exp_tab_data[0] = 32'd12;
    exp_tab_reg[1] = 5'd3; exp_tab_data[1] = 32'd5;
    reset = 1'b1; start = 1'b0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    step(); step();

    // Reset state
    check("rst_cpurst", {63'd0, cpu_reset}, 64'd1);
    check("rst_we",     {63'd0, im_we}, 64'd0);
    check("rst_busy",   {63'd0, busy}, 64'd0);
    check("rst_done",   {63'd0, done}, 64'd0);
    check("rst_pass",   {63'd0, pass}, 64'd0);
    check("rst_fcode",  {62'd0, fail_code}, 64'd0);
    check("rst_cycles", {32'd0, cycles}, 64'd0);
    check("rst_pidx",   {61'd0, prog_idx}, 64'd0);
    reset = 1'b0;
    step();
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Run 1: load, R9=12 match, R0 ignored, start in RUN ignored, R3=5 -> pass
    do_start();
    load_and_check(1'b1);
    wb(5'd9, 32'd12);
    check("r1_expidx", {63'd0, exp_idx}, 64'd1);
    wb(5'd0, 32'd3);
    check("r1_r0_skip", {63'd0, done}, 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("r1_start_ign_busy", {63'd0, busy}, 64'd1);
    check("r1_start_ign_idx",  {63'd0, exp_idx}, 64'd1);
    check("r1_start_ign_we",   {63'd0, im_we}, 64'd0);
    wb(5'd3, 32'd5);
    check("r1_done",   {63'd0, done}, 64'd1);
    check("r1_pass",   {63'd0, pass}, 64'd1);
    check("r1_fcode",  {62'd0, fail_code}, 64'd0);
    check("r1_busy",   {63'd0, busy}, 64'd0);
    check("r1_cpurst", {63'd0, cpu_reset}, 64'd1);
    check("r1_cycles", {32'd0, cycles}, 64'd4);
    wb(5'd7, 32'd1);
    step();
    check("r1_hold_done",   {63'd0, done}, 64'd1);
    check("r1_hold_pass",   {63'd0, pass}, 64'd1);
    check("r1_hold_cycles", {32'd0, cycles}, 64'd4);

    // Run 2: restart from DONE clears status; R3 written as 4 instead of 5
    do_start();
    check("r2_clr_done",   {63'd0, done}, 64'd0);
    check("r2_clr_pass",   {63'd0, pass}, 64'd0);
    check("r2_clr_cycles", {32'd0, cycles}, 64'd0);
    check("r2_clr_pidx",   {61'd0, prog_idx}, 64'd0);
    load_and_check(1'b0);
    wb(5'd9, 32'd12);
    wb(5'd3, 32'd4);
    check("r2_done",   {63'd0, done}, 64'd1);
    check("r2_pass",   {63'd0, pass}, 64'd0);
    check("r2_fcode",  {62'd0, fail_code}, 64'd1);
    check("r2_fidx",   {63'd0, fail_idx}, 64'd1);
    check("r2_cycles", {32'd0, cycles}, 64'd2);

    // Run 3: no writebacks -> timeout after exactly TO RUN cycles
    do_start();
    load_and_check(1'b0);
    for (int i = 0; i < TO - 1; i++) step();
    check("r3_not_yet",   {63'd0, done}, 64'd0);
    check("r3_cycles_19", {32'd0, cycles}, 64'(TO - 1));
    step();
    check("r3_done",   {63'd0, done}, 64'd1);
    check("r3_fcode",  {62'd0, fail_code}, 64'd2);
    check("r3_fidx",   {63'd0, fail_idx}, 64'd0);
    check("r3_cycles", {32'd0, cycles}, 64'(TO));
    check("r3_cpurst", {63'd0, cpu_reset}, 64'd1);
    $display("timeout run: cycles=%0d fail_code=%0d", cycles, fail_code);

    // Run 4: reset asserted while word 3 is being written, then a clean restart
    do_start();
    step(); step(); step();
    check("r4_word3_addr", {32'd0, im_addr}, 64'd12);
    reset = 1'b1;
    #1;
    check("r4_abort_we",     {63'd0, im_we}, 64'd0);
    check("r4_abort_cpurst", {63'd0, cpu_reset}, 64'd1);
    check("r4_abort_busy",   {63'd0, busy}, 64'd0);
    step();
    reset = 1'b0;
    step();
    check("r4_idle_we", {63'd0, im_we}, 64'd0);
    do_start();
    load_and_check(1'b0);
    wb(5'd9, 32'd12);
    wb(5'd3, 32'd5);
    check("r4_done",  {63'd0, done}, 64'd1);
    check("r4_pass",  {63'd0, pass}, 64'd1);
    check("r4_fcode", {62'd0, fail_code}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
